// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared types and constants for the oversampled SPI slave receiver.
//   state_e     : receive FSM states (IDLE, SHIFT, HOLD)
//   SPI_CPOL/CPHA : SPI mode this slave implements (mode 0)
//   cnt_width() : width of a bit counter able to hold the value DATA_W
// -----------------------------------------------------------------------------
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // SPI mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Synchronisers shallower than this are not metastability-safe.
    localparam int MIN_SYNC_STAGES = 2;

    localparam int DEFAULT_DATA_W = 32;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Bit counter width for the default frame length.
    localparam int CNT_W = cnt_width(DEFAULT_DATA_W);

endpackage

// File: rtl/spi_pin_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
// Multi-flop synchroniser for one asynchronous SPI pin.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; all flops load RST_VAL
//   d     : asynchronous pin
//   q     : synchronised pin (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module spi_pin_sync
    import spi_slave_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Never build a chain shorter than the safe minimum.
    localparam int DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// Oversampled SPI mode-0 slave. All pins are synchronised into ACLK, frames of
// DATA_W bits are deserialised MSB first and offered on a valid/ready port,
// while a word captured at frame start is shifted back out on MISO.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   SS[1:0]       : active-low slave selects, bit SLAVE_ID selects this slave
//   SCLK, MOSI    : SPI clock and data from master
//   MISO          : SPI data to master (0 while deselected)
//   tx_data       : response word, captured when the frame starts
//   rx_data/rx_valid/rx_ready : received word handshake
//   frame_err     : 1-cycle pulse, frame ended short or ran long
//   overrun       : 1-cycle pulse, word completed while rx_valid was held
// -----------------------------------------------------------------------------
module spi_slave_rx
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SLAVE_ID    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [1:0]        SS,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int          CNT_W   = cnt_width(DATA_W);
    localparam logic [1:0]  SS_MASK = 2'b01 << SLAVE_ID;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Select our SS bit through a mask so the other slave's bit has no path.
    logic ss_pin;
    assign ss_pin = ~|(~SS & SS_MASK);

    logic sel_n, sclk_s, mosi_s;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(ACLK), .rst_n(ARESETN), .d(ss_pin), .q(sel_n)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sclk (
        .clk(ACLK), .rst_n(ARESETN), .d(SCLK), .q(sclk_s)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(ACLK), .rst_n(ARESETN), .d(MOSI), .q(mosi_s)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic                hold_err_q, hold_err_d;
    logic                sclk_dly_q, sel_dly_q;
    logic                rise_q, fall_q;

    logic                rise_d, fall_d, sel_fall, sel_rise;
    logic                word_done;
    logic [DATA_W-1:0]   rx_word;

    // SCLK edges are registered once more before use. MOSI is still stable
    // at that point because the master holds each SCLK phase >= 2 ACLKs,
    // and the extra stage gives the SYNC_STAGES+2 completion latency.
    assign rise_d   =  sclk_s & ~sclk_dly_q & ~sel_n;
    assign fall_d   = ~sclk_s &  sclk_dly_q & ~sel_n;
    assign sel_fall = ~sel_n &  sel_dly_q;
    assign sel_rise =  sel_n & ~sel_dly_q;
    assign rx_word  = {rx_shift_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            hold_err_q  <= 1'b0;
            sclk_dly_q  <= SPI_CPOL;
            sel_dly_q   <= 1'b1;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            hold_err_q  <= hold_err_d;
            sclk_dly_q  <= sclk_s;
            sel_dly_q   <= sel_n;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        hold_err_d  = hold_err_q;
        word_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_fall) begin
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    hold_err_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (sel_rise) begin
                    // Deselect ends the frame; a partial word is an error.
                    if (bit_cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    if (rise_q) begin
                        rx_shift_d = rx_word;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            word_done = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                    if (fall_q) begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            HOLD: begin
                if (sel_rise) begin
                    state_d = IDLE;
                end else if (rise_q && !hold_err_q) begin
                    // Report an over-long frame only once.
                    frame_err_d = 1'b1;
                    hold_err_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed word lands if the slot is free or being emptied now.
        if (word_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        MISO = 1'b0;
        if (!sel_n) begin
            case (state_q)
                // Present the MSB as soon as select is seen, before the load.
                IDLE:    MISO = tx_data[DATA_W-1];
                SHIFT:   MISO = tx_shift_q[DATA_W-1];
                default: MISO = 1'b0;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [1:0]  SS;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters filled by the monitor
    int          fe_cnt, ov_cnt, acc_cnt, rv_rise;
    logic [31:0] acc_data;
    logic        rv_prev, miso_hi;

    spi_slave_rx #(.DATA_W(32), .SLAVE_ID(0), .SYNC_STAGES(2)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && rx_ready) begin
            acc_cnt++;
            acc_data = rx_data;
        end
        if (rx_valid && !rv_prev) rv_rise++;
        rv_prev = rx_valid;
        if (MISO) miso_hi = 1'b1;
    end

    // Inputs change 2 ns after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic clear_mon();
        fe_cnt = 0; ov_cnt = 0; acc_cnt = 0; rv_rise = 0;
        acc_data = 32'h0; miso_hi = 1'b0;
    endtask

    // Clock n bits of word (MSB first, zeros past bit 31); SCLK = ACLK/8.
    task automatic clock_bits(input logic [31:0] word, input int nbits,
                              output logic [31:0] miso_word);
        logic [31:0] tmp;
        miso_word = 32'h0;
        MOSI = word[31];
        cyc(4);
        for (int i = 0; i < nbits; i++) begin
            miso_word = {miso_word[30:0], MISO};
            SCLK = 1'b1;
            cyc(4);
            SCLK = 1'b0;
            tmp  = word << (i + 1);
            MOSI = tmp[31];
            cyc(4);
        end
    endtask

    task automatic spi_frame(input int ss_bit, input logic [31:0] word,
                             input int nbits, output logic [31:0] miso_word);
        SS[ss_bit] = 1'b0;
        clock_bits(word, nbits, miso_word);
        SS = 2'b11;
        cyc(8);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; SS = 2'b11; SCLK = 1'b0; MOSI = 1'b0;
        tx_data = 32'h0; rx_ready = 1'b1;
        cyc(3);
        n_tests++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data got %h want 0", rx_data); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        n_tests++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", MISO); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        ARESETN = 1'b1;
        cyc(4);
        $display("[TB] reset done");
    endtask

    task automatic test_basic();
        logic [31:0] m;
        clear_mon();
        tx_data = 32'hDEAD_BEEF; rx_ready = 1'b1;
        spi_frame(0, 32'hA5A5_1234, 32, m);
        n_tests++; if (acc_data !== 32'hA5A5_1234) begin n_fail++; $display("FAIL basic_rx_data got %h want a5a51234", acc_data); end
        n_tests++; if (acc_cnt !== 1) begin n_fail++; $display("FAIL basic_accepts got %0d want 1", acc_cnt); end
        n_tests++; if (rv_rise !== 1) begin n_fail++; $display("FAIL basic_valid_pulses got %0d want 1", rv_rise); end
        n_tests++; if (m !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_miso got %h want deadbeef", m); end
        n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL basic_frame_err got %0d want 0", fe_cnt); end
        $display("[TB] basic frame rx=%h miso=%h", acc_data, m);
    endtask

    task automatic test_short();
        logic [31:0] m;
        clear_mon();
        tx_data = 32'h0F0F_0F0F;
        spi_frame(0, 32'h5555_AAAA, 17, m);
        n_tests++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL short_frame_err got %0d want 1", fe_cnt); end
        n_tests++; if (rv_rise !== 0) begin n_fail++; $display("FAIL short_valid got %0d want 0", rv_rise); end
        clear_mon();
        spi_frame(0, 32'h0000_0001, 32, m);
        n_tests++; if (acc_data !== 32'h0000_0001 || acc_cnt !== 1) begin n_fail++; $display("FAIL short_next_rx got %h x%0d want 00000001 x1", acc_data, acc_cnt); end
        n_tests++; if (m !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL short_next_miso got %h want 0f0f0f0f", m); end
        n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL short_next_frame_err got %0d want 0", fe_cnt); end
        $display("[TB] short frame then rx=%h", acc_data);
    endtask

    task automatic test_long();
        logic [31:0] m;
        clear_mon();
        spi_frame(0, 32'hFFFF_0000, 34, m);
        n_tests++; if (acc_data !== 32'hFFFF_0000 || acc_cnt !== 1) begin n_fail++; $display("FAIL long_rx got %h x%0d want ffff0000 x1", acc_data, acc_cnt); end
        n_tests++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL long_frame_err got %0d want 1", fe_cnt); end
        $display("[TB] long frame rx=%h frame_err=%0d", acc_data, fe_cnt);
    endtask

    task automatic test_back_to_back_overrun();
        logic [31:0] m1, m2;
        clear_mon();
        rx_ready = 1'b0;
        tx_data = 32'h1234_5678;
        spi_frame(0, 32'h1111_1111, 32, m1);
        tx_data = 32'h8765_4321;
        spi_frame(0, 32'h2222_2222, 32, m2);
        n_tests++; if (m1 !== 32'h1234_5678 || m2 !== 32'h8765_4321) begin n_fail++; $display("FAIL b2b_miso got %h %h want 12345678 87654321", m1, m2); end
        n_tests++; if (rx_valid !== 1'b1 || rx_data !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_held got %b %h want 1 11111111", rx_valid, rx_data); end
        n_tests++; if (ov_cnt !== 1) begin n_fail++; $display("FAIL b2b_overrun got %0d want 1", ov_cnt); end
        n_tests++; if (acc_cnt !== 0) begin n_fail++; $display("FAIL b2b_early_accept got %0d want 0", acc_cnt); end
        rx_ready = 1'b1;
        cyc(2);
        n_tests++; if (acc_cnt !== 1 || acc_data !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_accept got %h x%0d want 11111111 x1", acc_data, acc_cnt); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_clear got %b want 0", rx_valid); end
        $display("[TB] overrun rx=%h overrun=%0d", acc_data, ov_cnt);
    endtask

    task automatic test_wrong_slave();
        logic [31:0] m;
        clear_mon();
        tx_data = 32'hFFFF_FFFF;
        spi_frame(1, 32'h3C3C_3C3C, 32, m);
        n_tests++; if (rv_rise !== 0) begin n_fail++; $display("FAIL wrong_slave_valid got %0d want 0", rv_rise); end
        n_tests++; if (miso_hi !== 1'b0 || m !== 32'h0) begin n_fail++; $display("FAIL wrong_slave_miso got %b %h want 0 0", miso_hi, m); end
        n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL wrong_slave_frame_err got %0d want 0", fe_cnt); end
        $display("[TB] wrong slave valid=%0d", rv_rise);
    endtask

    task automatic test_reset_mid();
        logic [31:0] m;
        clear_mon();
        tx_data = 32'hA5A5_A5A5;
        SS[0] = 1'b0;
        clock_bits(32'h9999_9999, 10, m);
        ARESETN = 1'b0;
        cyc(1);
        n_tests++; if (rx_data !== 32'h0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_rx got %h %b want 0 0", rx_data, rx_valid); end
        n_tests++; if (MISO !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_outs got %b %b %b want 0 0 0", MISO, frame_err, overrun); end
        SS = 2'b11; SCLK = 1'b0;
        cyc(3);
        ARESETN = 1'b1;
        cyc(4);
        tx_data = 32'h1357_9BDF;
        spi_frame(0, 32'hCAFE_F00D, 32, m);
        n_tests++; if (acc_data !== 32'hCAFE_F00D || acc_cnt !== 1) begin n_fail++; $display("FAIL midreset_next_rx got %h x%0d want cafef00d x1", acc_data, acc_cnt); end
        n_tests++; if (m !== 32'h1357_9BDF) begin n_fail++; $display("FAIL midreset_next_miso got %h want 13579bdf", m); end
        n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL midreset_frame_err got %0d want 0", fe_cnt); end
        $display("[TB] reset mid-frame then rx=%h", acc_data);
    endtask

    initial begin
        rv_prev = 1'b0;
        clear_mon();
        test_reset();
        test_basic();
        test_short();
        test_long();
        test_back_to_back_overrun();
        test_wrong_slave();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
